// File: rtl/aq_mipi_raw10_unpack_if.sv
// Bus bundle for the RAW10 unpacker: packed 32-bit payload in, 4-pixel AXI4-Stream video out.
interface aq_mipi_raw10_unpack_if;
  logic        fsync;
  logic        s_valid;
  logic [31:0] s_data;
  logic [39:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;

  // Environment side: drives the payload and the downstream ready.
  modport master (
    output fsync, s_valid, s_data, m_tready,
    input  m_tdata, m_tvalid, m_tuser, m_tlast
  );

  // Unpacker side: consumes the payload and drives the video stream.
  modport slave (
    input  fsync, s_valid, s_data, m_tready,
    output m_tdata, m_tvalid, m_tuser, m_tlast
  );
endinterface

// File: rtl/aq_mipi_raw10_unpack.sv
// RAW10 unpacker: 4 bytes/cycle from the CSI-2 word aligner into 4 x 10-bit pixel groups.
// A byte FIFO collects payload; every 5 bytes form one group on an AXI4-Stream output
// with SOF on tuser and end-of-line on tlast.
module aq_mipi_raw10_unpack #(
  parameter int PIXELS_PER_LINE = 1920,
  parameter int ACC_BYTES       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aq_mipi_raw10_unpack_if.slave bus,
  output logic                 overflow,
  output logic                 partial
);

  // Extended view: stored bytes followed by the incoming word, long enough for any shift.
  localparam int EXT_BYTES = ACC_BYTES + 5;
  localparam int IW        = $clog2(EXT_BYTES);
  localparam int CW        = IW + 1;
  localparam logic [CW-1:0] GROUP    = CW'(5);
  localparam logic [CW-1:0] WORD     = CW'(4);
  localparam logic [CW-1:0] DEPTH    = CW'(ACC_BYTES);
  localparam logic [16:0]   LINE_LEN = 17'(PIXELS_PER_LINE);

  // P_k = {B_k, B4[2k+1:2k]}; bytes arrive packed with B0 in the low byte.
  function automatic logic [39:0] unpack_group(input logic [39:0] b);
    logic [39:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) p[10*k +: 10] = {b[8*k +: 8], b[32+2*k +: 2]};
    return p;
  endfunction

  logic [7:0]    acc     [ACC_BYTES];
  logic [1:0]    tag     [ACC_BYTES];
  logic [7:0]    acc_nxt [ACC_BYTES];
  logic [1:0]    tag_nxt [ACC_BYTES];
  logic [7:0]    ext     [EXT_BYTES];
  logic [1:0]    ext_tag [EXT_BYTES];
  logic [CW-1:0] cnt, cnt_base, cnt_nxt, old_cnt, rm;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [15:0]   pix, pix_hs;
  logic [1:0]    cur_tag, pend_tag, push_tag;
  logic [39:0]   tdata, group_bytes;
  logic          tvalid, tuser, tlast, tlast_nxt;
  logic          sof, pending, s_valid_q;
  logic          rise, fall, hs, out_free, disc, pop, ovf, push;

  assign bus.m_tdata  = tdata;
  assign bus.m_tvalid = tvalid;
  assign bus.m_tuser  = tuser;
  assign bus.m_tlast  = tlast;

  // Decide flush/pop/discard/push for this cycle and build the next FIFO contents.
  always_comb begin
    rise     = bus.s_valid && !s_valid_q;
    fall     = !bus.s_valid && s_valid_q;
    push_tag = rise ? cur_tag + 2'd1 : cur_tag;
    hs       = tvalid && bus.m_tready;
    out_free = !tvalid || bus.m_tready;
    cnt_base = bus.fsync ? '0 : cnt;

    // Bytes still belonging to the line that has ended sit at the FIFO head.
    old_cnt = '0;
    for (int i = 0; i < ACC_BYTES; i++)
      if (CW'(i) < cnt && tag[i] == pend_tag) old_cnt = old_cnt + CW'(1);

    // An ended line with less than one group left is dropped instead of popped, so a
    // group never mixes bytes of two lines.
    disc = pending && !bus.fsync && (old_cnt < GROUP);
    // The incoming word may complete the group in the same cycle.
    pop  = !bus.fsync && !disc && out_free &&
           (cnt_base >= GROUP || (bus.s_valid && (cnt_base + WORD >= GROUP)));
    rm   = pop ? GROUP : (disc ? old_cnt : '0);
    ovf  = bus.s_valid && (cnt_base + WORD > DEPTH + rm);
    push = bus.s_valid && !ovf;
    cnt_nxt = cnt_base - rm + (push ? WORD : '0);

    for (int i = 0; i < EXT_BYTES; i++) begin
      ext[i]     = '0;
      ext_tag[i] = '0;
    end
    for (int i = 0; i < ACC_BYTES; i++) begin
      if (CW'(i) < cnt_base) begin
        ext[i]     = acc[i];
        ext_tag[i] = tag[i];
      end
    end
    wr_idx = '0;
    if (push) begin
      for (int l = 0; l < 4; l++) begin
        wr_idx          = IW'(cnt_base) + IW'(l);
        ext[wr_idx]     = bus.s_data[8*l +: 8];
        ext_tag[wr_idx] = push_tag;
      end
    end

    rd_idx = '0;
    for (int i = 0; i < ACC_BYTES; i++) begin
      rd_idx     = IW'(i) + IW'(rm);
      acc_nxt[i] = ext[rd_idx];
      tag_nxt[i] = ext_tag[rd_idx];
    end

    group_bytes = {ext[4], ext[3], ext[2], ext[1], ext[0]};
    pix_hs      = hs ? (tlast ? '0 : pix + 16'd4) : pix;
    tlast_nxt   = ({1'b0, pix_hs} + 17'd4) == LINE_LEN;
  end

  // Byte storage: contents are only meaningful below cnt, so no reset is needed.
  always_ff @(posedge clk) begin
    acc <= acc_nxt;
    tag <= tag_nxt;
  end

  // Control state, output register and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pix       <= '0;
      sof       <= 1'b0;
      pending   <= 1'b0;
      pend_tag  <= '0;
      cur_tag   <= '0;
      s_valid_q <= 1'b0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      tuser     <= 1'b0;
      tlast     <= 1'b0;
      overflow  <= 1'b0;
      partial   <= 1'b0;
    end else begin
      s_valid_q <= bus.s_valid;
      cnt       <= cnt_nxt;
      if (rise) cur_tag <= cur_tag + 2'd1;
      if (ovf) overflow <= 1'b1;
      if (disc && old_cnt != '0) partial <= 1'b1;

      if (bus.fsync) begin
        pending <= 1'b0;
      end else begin
        if (disc) pending <= 1'b0;
        if (fall) begin
          pending  <= 1'b1;
          pend_tag <= cur_tag;
        end
      end

      if (bus.fsync) begin
        tvalid <= 1'b0;
        tuser  <= 1'b0;
        tlast  <= 1'b0;
        tdata  <= '0;
        pix    <= '0;
        sof    <= 1'b1;
      end else begin
        pix <= pix_hs;
        if (hs && tuser) sof <= 1'b0;
        if (pop) begin
          tvalid <= 1'b1;
          tdata  <= unpack_group(group_bytes);
          tuser  <= sof && !(hs && tuser);
          tlast  <= tlast_nxt;
        end else if (hs) begin
          tvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aq_mipi_raw10_unpack.sv
// Directed bench for aq_mipi_raw10_unpack with PIXELS_PER_LINE=8 and ACC_BYTES=16.
module tb_aq_mipi_raw10_unpack;
  logic clk = 1'b0;
  logic rst_n;
  logic overflow, partial;
  int   errors = 0;
  int   checks = 0;

  logic [39:0] q_data [$];
  logic        q_user [$];
  logic        q_last [$];

  always #5 clk = ~clk;

  aq_mipi_raw10_unpack_if bus();

  aq_mipi_raw10_unpack #(.PIXELS_PER_LINE(8), .ACC_BYTES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .overflow (overflow),
    .partial  (partial)
  );

  // Record every completed output handshake (inputs are stable at the falling edge).
  always @(negedge clk) begin
    if (rst_n && bus.m_tvalid && bus.m_tready) begin
      q_data.push_back(bus.m_tdata);
      q_user.push_back(bus.m_tuser);
      q_last.push_back(bus.m_tlast);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [39:0] pk(input logic [9:0] p0, p1, p2, p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [31:0] w);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    tick();
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (n) tick();
  endtask

  task automatic clear_q();
    q_data.delete();
    q_user.delete();
    q_last.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.fsync = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_tready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata, overflow, partial} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b user=%b last=%b data=%h ovf=%b part=%b want all 0",
               bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata, overflow, partial);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %b want 0", bus.m_tvalid);
    end
  endtask

  task automatic test_first_group();
    clear_q();
    bus.m_tready = 1'b1;
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    word(32'h40302010);
    checks++;
    if (bus.m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL first_latency_w1: got valid=%b want 0", bus.m_tvalid);
    end
    word(32'h7060501B);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== pk(10'h043, 10'h082, 10'h0C1, 10'h100) ||
        bus.m_tuser !== 1'b1 || bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL first_group: got valid=%b data=%h user=%b last=%b want valid=1 data=%h user=1 last=0",
               bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast,
               pk(10'h043, 10'h082, 10'h0C1, 10'h100));
    end
  endtask

  task automatic test_line_tlast();
    logic [39:0] exp_d [4];
    logic [3:0]  exp_l, exp_u;
    exp_d[0] = pk(10'h043, 10'h082, 10'h0C1, 10'h100);
    exp_d[1] = pk(10'h140, 10'h181, 10'h1C2, 10'h203);
    exp_d[2] = pk(10'h004, 10'h008, 10'h00C, 10'h010);
    exp_d[3] = pk(10'h3FF, 10'h203, 10'h1FF, 10'h003);
    exp_l = 4'b1010;
    exp_u = 4'b0001;
    word(32'h0201E480);
    word(32'hFF000403);
    word(32'hFF007F80);
    idle(4);
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL line_group_count: got %0d want 4", q_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_data.size()) begin
        errors++;
        $display("FAIL line_group%0d: missing, want data=%h", i, exp_d[i]);
      end else if (q_data[i] !== exp_d[i] || q_last[i] !== exp_l[i] || q_user[i] !== exp_u[i]) begin
        errors++;
        $display("FAIL line_group%0d: got data=%h user=%b last=%b want data=%h user=%b last=%b",
                 i, q_data[i], q_user[i], q_last[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (partial !== 1'b0) begin
      errors++;
      $display("FAIL line_no_partial: got %b want 0", partial);
    end
  endtask

  task automatic test_partial();
    logic [39:0] exp_d [2];
    exp_d[0] = pk(10'h005, 10'h009, 10'h00C, 10'h010);
    exp_d[1] = pk(10'h01A, 10'h01E, 10'h020, 10'h024);
    clear_q();
    word(32'h04030201);
    word(32'h08070605);
    word(32'h0C0B0A09);
    checks++;
    if (partial !== 1'b0) begin
      errors++;
      $display("FAIL partial_early: got %b want 0", partial);
    end
    idle(4);
    checks++;
    if (q_data.size() != 2) begin
      errors++;
      $display("FAIL partial_group_count: got %0d want 2", q_data.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= q_data.size()) begin
        errors++;
        $display("FAIL partial_group%0d: missing, want data=%h", i, exp_d[i]);
      end else if (q_data[i] !== exp_d[i] || q_last[i] !== (i == 1) || q_user[i] !== 1'b0) begin
        errors++;
        $display("FAIL partial_group%0d: got data=%h user=%b last=%b want data=%h user=0 last=%b",
                 i, q_data[i], q_user[i], q_last[i], exp_d[i], (i == 1));
      end
    end
    checks++;
    if (partial !== 1'b1) begin
      errors++;
      $display("FAIL partial_flag: got %b want 1", partial);
    end
  endtask

  task automatic test_backpressure_overflow();
    logic [31:0] w [10];
    logic [39:0] exp_d [4];
    w[0] = 32'h03020100; w[1] = 32'h07060504; w[2] = 32'h0B0A0908;
    w[3] = 32'h0F0E0D0C; w[4] = 32'h13121110;
    for (int i = 5; i < 10; i++) w[i] = 32'hDEADBEEF;
    exp_d[0] = pk(10'h000, 10'h005, 10'h008, 10'h00C);
    exp_d[1] = pk(10'h015, 10'h01A, 10'h01C, 10'h020);
    exp_d[2] = pk(10'h02A, 10'h02F, 10'h030, 10'h034);
    exp_d[3] = pk(10'h03F, 10'h040, 10'h045, 10'h048);
    clear_q();
    bus.m_tready = 1'b0;
    word(w[0]);
    word(w[1]);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== exp_d[0]) begin
      errors++;
      $display("FAIL stall_first: got valid=%b data=%h want valid=1 data=%h",
               bus.m_tvalid, bus.m_tdata, exp_d[0]);
    end
    for (int k = 2; k < 10; k++) begin
      word(w[k]);
      checks++;
      if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== exp_d[0] || bus.m_tlast !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_w%0d: got valid=%b data=%h last=%b want valid=1 data=%h last=0",
                 k, bus.m_tvalid, bus.m_tdata, bus.m_tlast, exp_d[0]);
      end
      if (k == 4) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL overflow_early: got %b want 0", overflow);
        end
      end
      if (k == 5) begin
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL overflow_set: got %b want 1", overflow);
        end
      end
    end
    bus.m_tready = 1'b1;
    idle(6);
    checks++;
    if (q_data.size() != 4) begin
      errors++;
      $display("FAIL drain_group_count: got %0d want 4", q_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q_data.size()) begin
        errors++;
        $display("FAIL drain_group%0d: missing, want data=%h", i, exp_d[i]);
      end else if (q_data[i] !== exp_d[i] || q_last[i] !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL drain_group%0d: got data=%h last=%b want data=%h last=%b",
                 i, q_data[i], q_last[i], exp_d[i], (i % 2 == 1));
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_fsync_mid_line();
    logic [39:0] f0, f1;
    f0 = pk(10'h045, 10'h089, 10'h0CD, 10'h111);
    f1 = pk(10'h19A, 10'h1DE, 10'h222, 10'h266);
    bus.m_tready = 1'b0;
    word(32'hAAAAAAAA);
    word(32'hAAAAAAAA);
    checks++;
    if (bus.m_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL fsync_pre_valid: got %b want 1", bus.m_tvalid);
    end
    bus.fsync = 1'b1;
    word(32'h44332211);
    bus.fsync = 1'b0;
    checks++;
    if (bus.m_tvalid !== 1'b0 || bus.m_tuser !== 1'b0 || bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL fsync_clear: got valid=%b user=%b last=%b want 0 0 0",
               bus.m_tvalid, bus.m_tuser, bus.m_tlast);
    end
    clear_q();
    bus.m_tready = 1'b1;
    word(32'h88776655);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== f0 || bus.m_tuser !== 1'b1 || bus.m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL fsync_sof_group: got valid=%b data=%h user=%b last=%b want valid=1 data=%h user=1 last=0",
               bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, f0);
    end
    word(32'hCCBBAA99);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== f1 || bus.m_tuser !== 1'b0 || bus.m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL fsync_second_group: got valid=%b data=%h user=%b last=%b want valid=1 data=%h user=0 last=1",
               bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast, f1);
    end
    idle(4);
    checks++;
    if (q_data.size() != 2) begin
      errors++;
      $display("FAIL fsync_group_count: got %0d want 2", q_data.size());
    end
  endtask

  task automatic test_reset_mid_line();
    bus.m_tready = 1'b0;
    word(32'h11111111);
    word(32'h22222222);
    checks++;
    if (bus.m_tvalid !== 1'b1 || overflow !== 1'b1 || partial !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got valid=%b ovf=%b part=%b want 1 1 1",
               bus.m_tvalid, overflow, partial);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata, overflow, partial} !== 45'd0) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%b user=%b last=%b data=%h ovf=%b part=%b want all 0",
               bus.m_tvalid, bus.m_tuser, bus.m_tlast, bus.m_tdata, overflow, partial);
    end
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.m_tready = 1'b1;
    word(32'h04030201);
    word(32'h08070605);
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tuser !== 1'b0 || bus.m_tlast !== 1'b0 ||
        bus.m_tdata !== pk(10'h005, 10'h009, 10'h00C, 10'h010)) begin
      errors++;
      $display("FAIL rstmid_no_sof: got valid=%b data=%h user=%b last=%b want valid=1 data=%h user=0 last=0",
               bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast,
               pk(10'h005, 10'h009, 10'h00C, 10'h010));
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_first_group();
    test_line_tlast();
    test_partial();
    test_backpressure_overflow();
    test_fsync_mid_line();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
